// File: rtl/arm_ldm_stm_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_ldm_stm_seq_pkg
//  Description : Shared types and constants for the LDM/STM sequencer:
//                FSM state encodings, PC register index, instruction field
//                bit positions and a 16-bit population count helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package arm_ldm_stm_seq_pkg;

    // Sequencer states, explicitly encoded in 3 bits
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Register 15 is the program counter; loads to it go to the PC port
    localparam logic [3:0] PC_REG = 4'd15;

    // Instruction field positions
    localparam int c_BIT_P   = 24;
    localparam int c_BIT_U   = 23;
    localparam int c_BIT_W   = 21;
    localparam int c_BIT_L   = 20;
    localparam int c_RN_LSB  = 16;
    localparam int c_RN_MSB  = 19;

    // Number of registers named in a 16-bit register list
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage : arm_ldm_stm_seq_pkg
`default_nettype wire

// File: rtl/arm_reg_list_enc.sv
`default_nettype none
// ============================================================================
//  Module      : arm_reg_list_enc
//  Description : 16-to-4 lowest-set-bit priority encoder with valid flag.
//                Picks the next register of an LDM/STM list to service.
//  Revision    : 1.0 - initial release
// ============================================================================
module arm_reg_list_enc (
    input  logic [15:0] list_i,
    output logic [3:0]  idx_o,
    output logic        valid_o
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (list_i[i]) begin
                idx_o   = 4'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule : arm_reg_list_enc
`default_nettype wire

// File: rtl/arm_ldm_stm_seq.sv
`default_nettype none
// ============================================================================
//  Module      : arm_ldm_stm_seq
//  Description : Block load/store multiple (LDM/STM) sequencer. Latches the
//                instruction and base, computes the start address and base
//                writeback value, then issues one memory transfer per listed
//                register (lowest register at lowest address) and finally
//                performs the optional base writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module arm_ldm_stm_seq
    import arm_ldm_stm_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] inst,
    output logic [3:0]  read_rn,
    input  logic [31:0] rn_out,
    output logic [3:0]  read_rm,
    input  logic [31:0] rm_out,
    output logic [3:0]  write_rd,
    output logic        rd_we,
    output logic [31:0] rd_in,
    output logic        pc_we,
    output logic [31:0] pc_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done
);

    state_e      r_state_q, w_state_d;
    logic        r_p_q, w_p_d;
    logic        r_u_q, w_u_d;
    logic        r_w_q, w_w_d;
    logic        r_l_q, w_l_d;
    logic [3:0]  r_rn_q, w_rn_d;
    logic [15:0] r_list_q, w_list_d;
    logic [31:0] r_base_q, w_base_d;
    logic [31:0] r_addr_q, w_addr_d;
    logic [31:0] r_wb_q, w_wb_d;
    logic        r_skip_wb_q, w_skip_wb_d;

    logic [3:0]  w_enc_idx;
    logic        w_enc_valid;
    logic [4:0]  w_n;
    logic [31:0] w_span;

    // Only the addressing-mode, writeback, load and register fields matter here
    logic        w_unused_inst;
    assign w_unused_inst = ^{inst[31:25], inst[22]};

    arm_reg_list_enc u_enc (
        .list_i  (r_list_q),
        .idx_o   (w_enc_idx),
        .valid_o (w_enc_valid)
    );

    // Transfer count and its byte span (4 bytes per register)
    assign w_n    = popcount16(r_list_q);
    assign w_span = {25'd0, w_n, 2'b00};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_p_q       <= 1'b0;
            r_u_q       <= 1'b0;
            r_w_q       <= 1'b0;
            r_l_q       <= 1'b0;
            r_rn_q      <= '0;
            r_list_q    <= '0;
            r_base_q    <= '0;
            r_addr_q    <= '0;
            r_wb_q      <= '0;
            r_skip_wb_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_p_q       <= w_p_d;
            r_u_q       <= w_u_d;
            r_w_q       <= w_w_d;
            r_l_q       <= w_l_d;
            r_rn_q      <= w_rn_d;
            r_list_q    <= w_list_d;
            r_base_q    <= w_base_d;
            r_addr_q    <= w_addr_d;
            r_wb_q      <= w_wb_d;
            r_skip_wb_q <= w_skip_wb_d;
        end
    end

    // Next-state, datapath update and output decode
    always_comb begin
        w_state_d   = r_state_q;
        w_p_d       = r_p_q;
        w_u_d       = r_u_q;
        w_w_d       = r_w_q;
        w_l_d       = r_l_q;
        w_rn_d      = r_rn_q;
        w_list_d    = r_list_q;
        w_base_d    = r_base_q;
        w_addr_d    = r_addr_q;
        w_wb_d      = r_wb_q;
        w_skip_wb_d = r_skip_wb_q;

        read_rn   = '0;
        read_rm   = '0;
        write_rd  = '0;
        rd_we     = 1'b0;
        rd_in     = '0;
        pc_we     = 1'b0;
        pc_in     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (r_state_q != ST_IDLE);
        done      = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                // Base read address is presented so rn_out is valid with start
                read_rn = inst[c_RN_MSB:c_RN_LSB];
                if (start) begin
                    w_p_d     = inst[c_BIT_P];
                    w_u_d     = inst[c_BIT_U];
                    w_w_d     = inst[c_BIT_W];
                    w_l_d     = inst[c_BIT_L];
                    w_rn_d    = inst[c_RN_MSB:c_RN_LSB];
                    w_list_d  = inst[15:0];
                    w_base_d  = rn_out;
                    w_state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                // Transfers always ascend; descending modes start low and climb
                case ({r_p_q, r_u_q})
                    2'b01:   w_addr_d = r_base_q;                    // IA
                    2'b11:   w_addr_d = r_base_q + 32'd4;            // IB
                    2'b00:   w_addr_d = r_base_q - w_span + 32'd4;   // DA
                    default: w_addr_d = r_base_q - w_span;           // DB
                endcase
                w_wb_d      = r_u_q ? (r_base_q + w_span) : (r_base_q - w_span);
                // A load that includes the base leaves the loaded value in place
                w_skip_wb_d = r_l_q && r_list_q[r_rn_q];
                w_state_d   = (w_n == 5'd0) ? ST_DONE : ST_XFER;
            end

            ST_XFER: begin
                mem_req   = 1'b1;
                mem_we    = ~r_l_q;
                mem_addr  = r_addr_q;
                read_rm   = w_enc_idx;
                mem_wdata = r_l_q ? 32'd0 : rm_out;
                if (mem_ack && w_enc_valid) begin
                    if (r_l_q) begin
                        if (w_enc_idx == PC_REG) begin
                            pc_we = 1'b1;
                            pc_in = mem_rdata;
                        end else begin
                            rd_we    = 1'b1;
                            write_rd = w_enc_idx;
                            rd_in    = mem_rdata;
                        end
                    end
                    w_list_d = r_list_q & ~(16'd1 << w_enc_idx);
                    w_addr_d = r_addr_q + 32'd4;
                    if (w_list_d == 16'd0) begin
                        w_state_d = (r_w_q && !r_skip_wb_q) ? ST_WB : ST_DONE;
                    end
                end
            end

            ST_WB: begin
                rd_we     = 1'b1;
                write_rd  = r_rn_q;
                rd_in     = r_wb_q;
                w_state_d = ST_DONE;
            end

            ST_DONE: begin
                done      = 1'b1;
                w_state_d = ST_IDLE;
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

endmodule : arm_ldm_stm_seq
`default_nettype wire

// File: tb/tb_arm_ldm_stm_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arm_ldm_stm_seq
//  Description : Scoreboard bench for arm_ldm_stm_seq. Stimulus pushes the
//                expected transfers, register writes and done latency into a
//                queue; a monitor pops and compares as the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_ldm_stm_seq;

    localparam int c_EV_MEM  = 0;
    localparam int c_EV_RD   = 1;
    localparam int c_EV_PC   = 2;
    localparam int c_EV_DONE = 3;

    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] inst;
    logic [3:0]  read_rn;
    logic [31:0] rn_out;
    logic [3:0]  read_rm;
    logic [31:0] rm_out;
    logic [3:0]  write_rd;
    logic        rd_we;
    logic [31:0] rd_in;
    logic        pc_we;
    logic [31:0] pc_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;

    logic [31:0] regs [16];
    ev_t         exp_q [$];
    int          checks;
    int          errors;
    int          cyc;
    int          start_cyc;
    int          ack_delay;
    int          wait_cnt;

    logic        p_pend;
    logic        p_we;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;

    arm_ldm_stm_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inst      (inst),
        .read_rn   (read_rn),
        .rn_out    (rn_out),
        .read_rm   (read_rm),
        .rm_out    (rm_out),
        .write_rd  (write_rd),
        .rd_we     (rd_we),
        .rd_in     (rd_in),
        .pc_we     (pc_we),
        .pc_in     (pc_in),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done)
    );

    // Register file model: combinational read ports
    assign rn_out = regs[read_rn];
    assign rm_out = regs[read_rm];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: ack after ack_delay waiting cycles, load data = addr ^ A5A50000
    initial begin
        wait_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !rst) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr ^ 32'hA5A5_0000;
                    wait_cnt  = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'd0;
                    wait_cnt  = wait_cnt + 1;
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'd0;
                wait_cnt  = 0;
            end
        end
    end

    task automatic push(input int kind, input logic we, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.we   = we;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input string nm, input int kind, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected: got kind=%0d we=%0b a=%h d=%h, required nothing", nm, kind, we, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.we !== we || e.a !== a || e.d !== d) begin
                errors++;
                $display("FAIL %s: got kind=%0d we=%0b a=%h d=%h, required kind=%0d we=%0b a=%h d=%h",
                         nm, kind, we, a, d, e.kind, e.we, e.a, e.d);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] need);
        checks++;
        if (got !== need) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, need);
        end
    endtask

    // Monitor: pop-and-compare on every DUT-produced event, plus request stability
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req && p_pend) begin
                checks++;
                if (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata) begin
                    errors++;
                    $display("FAIL req_stable: got addr=%h we=%0b wd=%h, required addr=%h we=%0b wd=%h",
                             mem_addr, mem_we, mem_wdata, p_addr, p_we, p_wdata);
                end
            end
            if (mem_req && mem_ack) observe("mem", c_EV_MEM, mem_we, mem_addr, mem_wdata);
            if (rd_we)              observe("rd", c_EV_RD, 1'b1, {28'd0, write_rd}, rd_in);
            if (pc_we)              observe("pc", c_EV_PC, 1'b1, 32'd0, pc_in);
            if (done)               observe("done", c_EV_DONE, 1'b0, 32'(cyc - start_cyc), 32'd0);
            p_pend  = mem_req && !mem_ack;
            p_addr  = mem_addr;
            p_we    = mem_we;
            p_wdata = mem_wdata;
        end else begin
            p_pend = 1'b0;
        end
    end

    // Issue one instruction; optionally pulse start again while the DUT is busy
    task automatic run_op(input logic [31:0] v, input bit poke_busy);
        int n;
        @(negedge clk);
        inst      = v;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1 start  = 1'b0;
        if (poke_busy) begin
            @(posedge clk);
            @(negedge clk);
            inst  = 32'hE8A0_0000;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d expected events still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        start_cyc = 0;
        ack_delay = 0;
        p_pend    = 1'b0;
        p_we      = 1'b0;
        p_addr    = '0;
        p_wdata   = '0;
        for (int i = 0; i < 16; i++) regs[i] = 32'd0;
        regs[0]   = 32'h0000_1000;
        regs[1]   = 32'h1111_1111;
        regs[2]   = 32'h2222_2222;
        regs[3]   = 32'h3333_3333;
        regs[4]   = 32'h4444_4444;
        regs[5]   = 32'h0000_3000;
        regs[7]   = 32'h7777_7777;
        regs[13]  = 32'h0000_2000;
        rst       = 1'b1;
        start     = 1'b0;
        inst      = 32'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {26'd0, busy, done, mem_req, mem_we, rd_we, pc_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_data", mem_wdata | rd_in | pc_in, 32'd0);
        chk("rst_idx", {20'd0, read_rn, read_rm, write_rd}, 32'd0);
        rst = 1'b0;

        // STMIA r0!,{r1,r2,r4}, with a stray start while busy
        push(c_EV_MEM, 1'b1, 32'h0000_1000, 32'h1111_1111);
        push(c_EV_MEM, 1'b1, 32'h0000_1004, 32'h2222_2222);
        push(c_EV_MEM, 1'b1, 32'h0000_1008, 32'h4444_4444);
        push(c_EV_RD,  1'b1, 32'd0, 32'h0000_100C);
        push(c_EV_DONE, 1'b0, 32'd6, 32'd0);
        run_op(32'hE8A0_0016, 1'b1);

        // LDMDB r13,{r4,pc}
        push(c_EV_MEM, 1'b0, 32'h0000_1FF8, 32'd0);
        push(c_EV_RD,  1'b1, 32'd4, 32'hA5A5_1FF8);
        push(c_EV_MEM, 1'b0, 32'h0000_1FFC, 32'd0);
        push(c_EV_PC,  1'b1, 32'd0, 32'hA5A5_1FFC);
        push(c_EV_DONE, 1'b0, 32'd4, 32'd0);
        run_op(32'hE91D_8010, 1'b0);

        // Empty list
        push(c_EV_DONE, 1'b0, 32'd2, 32'd0);
        run_op(32'hE8A0_0000, 1'b0);

        // STMDA r5!,{r3,r7} with three wait cycles per transfer
        ack_delay = 3;
        push(c_EV_MEM, 1'b1, 32'h0000_2FFC, 32'h3333_3333);
        push(c_EV_MEM, 1'b1, 32'h0000_3000, 32'h7777_7777);
        push(c_EV_RD,  1'b1, 32'd5, 32'h0000_2FF8);
        push(c_EV_DONE, 1'b0, 32'd11, 32'd0);
        run_op(32'hE825_0088, 1'b0);
        ack_delay = 0;

        // LDMIA r0!,{r0,r1}: base in list, no writeback
        push(c_EV_MEM, 1'b0, 32'h0000_1000, 32'd0);
        push(c_EV_RD,  1'b1, 32'd0, 32'hA5A5_1000);
        push(c_EV_MEM, 1'b0, 32'h0000_1004, 32'd0);
        push(c_EV_RD,  1'b1, 32'd1, 32'hA5A5_1004);
        push(c_EV_DONE, 1'b0, 32'd4, 32'd0);
        run_op(32'hE8B0_0003, 1'b0);

        // STMIB r2!,{r0}
        push(c_EV_MEM, 1'b1, 32'h2222_2226, 32'h0000_1000);
        push(c_EV_RD,  1'b1, 32'd2, 32'h2222_2226);
        push(c_EV_DONE, 1'b0, 32'd4, 32'd0);
        run_op(32'hE9A2_0001, 1'b0);

        // Reset in the middle of a slow STMIA r0,{r1}
        ack_delay = 5;
        @(negedge clk);
        inst      = 32'hE880_0002;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1 start  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("xfer_req_before_rst", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("idle_after_rst", {30'd0, busy, mem_req}, 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_arm_ldm_stm_seq
`default_nettype wire

// File: doc/arm_ldm_stm_seq.md
ARM_LDM_STM_SEQ -- requirements
Module: arm_ldm_stm_seq

Interface
REQ-001 Parameters SHALL be none; widths are fixed by the ARM architecture.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle request to execute the LDM/STM on inst; condition already passed.
REQ-005 inst  in  32  instruction; fields used: P[24], U[23], W[21], L[20], Rn[19:16], list[15:0].
REQ-006 read_rn  out  4  register-file read address for base; equals inst[19:16].
REQ-007 rn_out  in  32  base register value, sampled at start.
REQ-008 read_rm  out  4  register-file read address for STM data.
REQ-009 rm_out  in  32  STM store data.
REQ-010 write_rd / rd_we / rd_in  out  4/1/32  register-file write port.
REQ-011 pc_we / pc_in  out  1/32  PC write port.
REQ-012 mem_req / mem_we / mem_addr / mem_wdata  out  1/1/32/32  memory request channel.
REQ-013 mem_ack / mem_rdata  in  1/32  memory completion and load data.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, XFER, WB, DONE.
REQ-017 In IDLE, start SHALL latch P, U, W, L, Rn, list and rn_out, and move to SETUP; start outside IDLE SHALL be ignored.
REQ-018 SETUP SHALL compute n = popcount(list), start address (IA: Rn; IB: Rn+4; DA: Rn-4n+4; DB: Rn-4n) and writeback value (U ? Rn+4n : Rn-4n), all modulo 2^32, in one cycle.
REQ-019 SETUP with n==0 SHALL go to DONE with no memory access and no writeback.
REQ-020 XFER SHALL service registers lowest-numbered first at ascending word addresses, regardless of U.
REQ-021 In XFER: mem_req=1, mem_we=~L, read_rm=current register, mem_wdata=rm_out; all SHALL hold stable until mem_ack.
REQ-022 On mem_ack with L=1: write current register (rd_we=1, write_rd=reg, rd_in=mem_rdata) in the ack cycle; reg 15 SHALL assert pc_we/pc_in instead of rd_we.
REQ-023 On mem_ack: clear the serviced list bit, add 4 to address; after the last transfer go to WB if W=1, else DONE.
REQ-024 WB SHALL assert rd_we for one cycle with write_rd=Rn and rd_in=writeback value.
REQ-025 If L=1 and Rn is in list, WB SHALL be skipped; the loaded value wins.
REQ-026 mem_ack outside XFER SHALL be ignored.
REQ-027 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-028 With single-cycle ack, done SHALL assert n+2 cycles after the start cycle, or n+3 if WB runs.
REQ-029 Deasserted outputs SHALL drive zero.

Reset
REQ-030 rst SHALL force IDLE at the next edge from any state, and drop any pending mem_req without completion.
REQ-031 After reset: busy=0, done=0, mem_req=0, rd_we=0, pc_we=0, and all data and address outputs 0.

Structure
REQ-032 The shared defines header SHALL hold the state encodings, PC_REG=15, and the P/U/W/L bit positions.
REQ-033 One sub-module, arm_reg_list_enc, SHALL provide the 16-to-4 lowest-set-bit encoder with a valid flag.

Verification
REQ-034 STMIA r0!,{r1,r2,r4} (r0=0x1000), immediate ack -> stores to 0x1000/0x1004/0x1008 with r1/r2/r4 data, r0<=0x100C, done 6 cycles after start.
REQ-035 LDMDB r13,{r4,pc} (r13=0x2000), W=0 -> loads 0x1FF8 into r4 and 0x1FFC into PC via pc_we; no writeback.
REQ-036 Empty list -> done 2 cycles after start, mem_req never asserted.
REQ-037 Ack delayed 3 cycles per transfer -> mem_addr/mem_we/mem_wdata stable throughout; exactly one transfer per ack.
REQ-038 LDMIA r0!,{r0,r1} -> r0 gets loaded word, no WB cycle.
REQ-039 rst during XFER -> IDLE next cycle with busy=0 and mem_req=0; start pulsed while busy -> ignored.
